// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver, LSB first, with a small first-word-fall-through FIFO.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per bit (16..65535)
//   FIFO_DEPTH    receive FIFO entries (power of two, 2..16)
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   rx_pin     serial input, idle high, asynchronous to clk
//   rx_byte    FIFO head byte (0 while the FIFO is empty)
//   rx_valid   FIFO not empty
//   rx_ack     pops the head byte
//   frame_err  one-cycle pulse: stop bit sampled low, byte dropped
//   overrun    one-cycle pulse: byte completed while FIFO full, byte dropped
//   busy       receiver FSM not idle
//
// Consumer handshake: rx_valid/rx_ack follow valid/ready rules. A byte is
// transferred on every rising clk edge where rx_valid and rx_ack are both 1;
// rx_ack while rx_valid is 0 has no effect. rx_byte is stable while rx_valid
// is high and no transfer has happened.

module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_pin,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int          AW     = $clog2(FIFO_DEPTH);
  localparam logic [15:0] LAST   = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] MID    = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] MID_M1 = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] MID_P1 = 16'(CLKS_PER_BIT / 2 + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  // Two-flop synchronizer; resets to the idle (high) line level.
  logic sync1, sync2, rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= rx_pin;
      sync2 <= sync1;
    end
  end

  assign rx_s = sync2;

  // Receiver state
  state_t      state, state_n;
  logic [15:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic        v0, v0_n, v1, v1_n;
  logic        vote, push, ferr_n, ovr_n;

  // FIFO state
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        empty, full, pop, room;

  // Majority of the samples at mid-1, mid and the live sample at mid+1.
  assign vote = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      v0        <= 1'b1;
      v1        <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      shreg     <= shreg_n;
      v0        <= v0_n;
      v1        <= v1_n;
      frame_err <= ferr_n;
      overrun   <= ovr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    v0_n    = v0;
    v1_n    = v1;
    push    = 1'b0;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;

    if (state == START || state == DATA || state == STOP) begin
      cnt_n = (cnt == LAST) ? 16'd0 : 16'(cnt + 16'd1);
      if (cnt == MID_M1) v0_n = rx_s;
      if (cnt == MID)    v1_n = rx_s;
    end

    case (state)
      IDLE: begin
        // The falling-edge cycle counts as cnt 0 of the start bit.
        if (!rx_s) begin
          state_n = START;
          cnt_n   = 16'd1;
        end
      end
      START: begin
        if (cnt == MID_P1 && vote) begin
          state_n = IDLE;
          cnt_n   = 16'd0;
        end else if (cnt == LAST) begin
          state_n = DATA;
          bit_n   = 3'd0;
        end
      end
      DATA: begin
        if (cnt == MID_P1) shreg_n = {vote, shreg[7:1]};
        if (cnt == LAST) begin
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = 3'(bit_idx + 3'd1);
        end
      end
      STOP: begin
        // Decide mid-stop-bit so a following start bit is never missed.
        if (cnt == MID_P1) begin
          cnt_n = 16'd0;
          if (vote) begin
            state_n = IDLE;
            if (room) push  = 1'b1;
            else      ovr_n = 1'b1;
          end else begin
            state_n = BREAK;
            ferr_n  = 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // FIFO: pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop   = rx_ack && !empty;
  // A simultaneous pop frees the slot the push needs.
  assign room  = !full || pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= shreg;
  end

  assign rx_valid = !empty;
  assign rx_byte  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver, 8N1, LSB first. It is the receive-side counterpart of the `uart` transmitter on the `clk100` domain. It decodes the `uart_rx_pin` line into bytes and buffers them in a small first-word-fall-through FIFO. Control and test FSMs consume these bytes as host commands (memory-test start, DAC setpoint, sampler start).

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per bit (100 MHz / 115200); legal range 16..65535.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of two, 2..16.

- `clk`  in  1  system clock (`clk100`).
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_pin`  in  1  serial input, idle high, asynchronous to `clk`.
- `rx_byte`  out  8  FIFO head byte; valid when `rx_valid`=1.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ack`  in  1  pops the head when `rx_valid`=1; ignored otherwise.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte completed while FIFO full, byte dropped.
- `busy`  out  1  receiver FSM not in IDLE.

## Operation
- **Input synchronizer:** `rx_pin` passes through 2 flops before all logic uses it. Both flops reset to 1.
- **Bit counter:** `cnt` is 16 bits wide, runs 0..CLKS_PER_BIT-1 and then wraps. mid = CLKS_PER_BIT/2, integer division.
- **Bit decision:** each bit is a majority vote of the synced line at `cnt` = mid-1, mid and mid+1. The vote is resolved at `cnt` = mid+1.
- **FSM states:** IDLE, START, DATA, STOP, BREAK.
  - IDLE: synced line = 0 → START, `cnt`←1.
  - START: vote = 1 → IDLE (glitch). No flag is raised and no byte is pushed. Vote = 0 → continue; at `cnt` = CLKS_PER_BIT-1 → DATA, bit index ← 0.
  - DATA: the vote shifts into `shreg[7]` with a right shift, so the data is LSB first. At `cnt` = CLKS_PER_BIT-1, the bit index increments; after bit 7 → STOP.
  - STOP: the decision is taken at `cnt` = mid+1; the FSM does not wait for the end of the stop bit.
    - Vote = 1 and the FIFO has room → push `shreg` → IDLE.
    - Vote = 1 and the FIFO is full → `overrun` pulse, byte dropped → IDLE.
    - Vote = 0 → `frame_err` pulse, byte dropped → BREAK.
  - BREAK: wait for synced line = 1 → IDLE. A held-low line never starts a frame.
- **FIFO:**
  - Read and write pointers are `$clog2(FIFO_DEPTH)`+1 bits wide; full and empty are decided from the MSB comparison.
  - `rx_byte` shows the head entry combinationally from the registered storage.
  - A push and a pop in the same cycle while full: the pop frees a slot, the push is accepted, `overrun` stays 0 and the count is unchanged.
  - A push while empty makes `rx_valid` = 1 on the next cycle. An `rx_ack` in the push cycle is ignored because `rx_valid` was 0.
  - Pointers wrap modulo 2·FIFO_DEPTH.

## Timing
- **Reset values:**
  - `rx_byte` = 0, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0, `busy` = 0.
  - FSM = IDLE, FIFO empty, synchronizer = 11.
- **Reset mid-frame:** the partial byte is discarded. The line must show a new falling edge after reset before a frame is received.
- **Start detection:** 2 cycles of synchronizer latency from the `rx_pin` falling edge to START. `busy` rises in the same cycle as START entry.
- **Byte latency:** `rx_valid` rises about 9.5·CLKS_PER_BIT + 4 cycles after the start-bit falling edge, assuming the FIFO was empty. This is 1 cycle after the STOP decision.
- **Error flags:** `frame_err` and `overrun` are high for exactly one cycle, in the cycle after the STOP decision.
- **Consumer handshake:** on `rx_ack`, `rx_byte` and `rx_valid` update on the next clock edge. Back-to-back acks drain one byte per cycle.
- **Baud tolerance:** frames with up to ±3% baud error relative to CLKS_PER_BIT must decode correctly.
- **Back-to-back frames:** a frame whose start bit immediately follows the previous stop bit (no idle gap) must be received, because IDLE is re-entered mid-stop-bit.

## Test plan
All scenarios use CLKS_PER_BIT = 16 and FIFO_DEPTH = 4.
1. Send 0x55, then 0x01, then 0x80 with no idle gap → `rx_byte` shows 0x55, 0x01, 0x80 in order after acks. `frame_err` and `overrun` stay 0.
2. Drive `rx_pin` low for 5 cycles while idle → `busy` pulses, then returns to 0. No push and no flags.
3. Send 0xA3 with stop bit = 0, hold the line low for 3 bit times, release it, then send 0x3C → one `frame_err` pulse, 0xA3 never appears, 0x3C is received.
4. Send 0x10..0x14 without asserting `rx_ack` → four bytes buffered and one `overrun` pulse on 0x14. Four acks return 0x10..0x13, then `rx_valid` = 0.
5. With the FIFO full, assert `rx_ack` in the exact cycle 0x20 is pushed → `overrun` = 0. The FIFO stays full with 0x20 last.
6. Assert `rst` during data bit 4 of 0x7E → all outputs 0 in the same cycle. The next frame 0xC3 is received correctly. A sweep at ±3% bit period also decodes 0x00..0xFF correctly.
